ysyx_25010008_axil_sram: RTL and testbench

YSYX_25010008_AXIL_SRAM -- requirements
Module: ysyx_25010008_axil_sram

---
 rtl/ysyx_25010008_axil_sram_if.sv | 42 ++++
 rtl/ysyx_25010008_axil_sram.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ysyx_25010008_axil_sram.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25010008_axil_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25010008_axil_sram_if
// Description : AXI4-Lite channel bundle (AR, R, AW, W, B) shared by the
//               SRAM slave and whatever master drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_25010008_axil_sram_if;
  // Read address channel
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25010008_axil_sram.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25010008_axil_sram
// Description : Single-outstanding AXI4-Lite SRAM slave with independent read
//               and write engines and programmable access latency.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25010008_axil_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 2,
  parameter int          WRITE_LAT   = 2
) (
  input  wire logic                 clock,
  input  wire logic                 reset,
  ysyx_25010008_axil_sram_if.slave  bus
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES  = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RLAT        = 4'(READ_LAT);
  localparam logic [3:0]  WLAT        = 4'(WRITE_LAT);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Compared in 33 bits so a window touching the top of the map cannot wrap.
  function automatic logic addr_hit(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, ADDR_BASE}) &&
           (({1'b0, a} - {1'b0, ADDR_BASE}) < SPAN_BYTES);
  endfunction

  // Byte offset to word index; the low two address bits drop out here.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  // Storage is deliberately left without a reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  r_state_e    r_state_q;
  logic [3:0]  r_cnt_q;
  logic [31:0] raddr_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic [31:0] rd_addr_d;
  logic        rd_hit_d;
  logic [31:0] rd_data_d;
  logic        rd_fire_d;

  // Select the address being answered and decide whether data lands this edge.
  always_comb begin
    rd_addr_d = (r_state_q == R_IDLE) ? bus.araddr : raddr_q;
    rd_hit_d  = addr_hit(rd_addr_d);
    rd_data_d = rd_hit_d ? mem_q[addr_idx(rd_addr_d)] : 32'h0;
    rd_fire_d = ((r_state_q == R_IDLE) && bus.arvalid && (READ_LAT == 0)) ||
                ((r_state_q == R_WAIT) && (r_cnt_q == 4'd1));
  end

  // Read FSM: accept AR, count down the latency, then hold R until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      raddr_q   <= 32'h0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (bus.arvalid) begin
            raddr_q   <= bus.araddr;
            arready_q <= 1'b0;
            if (rd_fire_d) begin
              r_state_q <= R_RESP;
              rvalid_q  <= 1'b1;
              rdata_q   <= rd_data_d;
              rresp_q   <= rd_hit_d ? RESP_OKAY : RESP_SLVERR;
            end else begin
              r_state_q <= R_WAIT;
              r_cnt_q   <= RLAT;
            end
          end
        end
        R_WAIT: begin
          if (rd_fire_d) begin
            r_state_q <= R_RESP;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data_d;
            rresp_q   <= rd_hit_d ? RESP_OKAY : RESP_SLVERR;
          end else begin
            r_cnt_q <= r_cnt_q - 4'd1;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  w_state_e    w_state_q;
  logic [3:0]  w_cnt_q;
  logic        aw_have_q;
  logic        w_have_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic        aw_take_d;
  logic        w_take_d;
  logic        both_d;
  logic [31:0] wr_addr_d;
  logic [31:0] wr_data_d;
  logic [3:0]  wr_strb_d;
  logic        wr_hit_d;
  logic        wr_fire_d;
  logic        commit_d;
  logic [31:0] merged_d;

  // Channel capture and commit decision; stored halves win over the live bus
  // so AW and W may arrive in either order.
  always_comb begin
    aw_take_d = (w_state_q == W_IDLE) && !aw_have_q && bus.awvalid;
    w_take_d  = (w_state_q == W_IDLE) && !w_have_q && bus.wvalid;
    both_d    = (w_state_q == W_IDLE) && (aw_have_q || aw_take_d) && (w_have_q || w_take_d);
    wr_addr_d = aw_have_q ? awaddr_q : bus.awaddr;
    wr_data_d = w_have_q ? wdata_q : bus.wdata;
    wr_strb_d = w_have_q ? wstrb_q : bus.wstrb;
    wr_hit_d  = addr_hit(wr_addr_d);
    wr_fire_d = (both_d && (WRITE_LAT == 0)) ||
                ((w_state_q == W_WAIT) && (w_cnt_q == 4'd1));
    commit_d  = wr_fire_d && wr_hit_d && !reset;
    merged_d  = mem_q[addr_idx(wr_addr_d)];
    for (int b = 0; b < 4; b++) begin
      if (wr_strb_d[b]) begin
        merged_d[8*b +: 8] = wr_data_d[8*b +: 8];
      end
    end
  end

  // Write FSM: gather AW and W, wait out the latency, then hold B until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_take_d) begin
            awaddr_q  <= bus.awaddr;
            aw_have_q <= 1'b1;
            awready_q <= 1'b0;
          end
          if (w_take_d) begin
            wdata_q   <= bus.wdata;
            wstrb_q   <= bus.wstrb;
            w_have_q  <= 1'b1;
            wready_q  <= 1'b0;
          end
          if (both_d) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            if (wr_fire_d) begin
              w_state_q <= W_RESP;
              bvalid_q  <= 1'b1;
              bresp_q   <= wr_hit_d ? RESP_OKAY : RESP_SLVERR;
            end else begin
              w_state_q <= W_WAIT;
              w_cnt_q   <= WLAT;
            end
          end
        end
        W_WAIT: begin
          if (wr_fire_d) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_hit_d ? RESP_OKAY : RESP_SLVERR;
          end else begin
            w_cnt_q <= w_cnt_q - 4'd1;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
          bvalid_q  <= 1'b0;
          aw_have_q <= 1'b0;
          w_have_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Memory commit on the edge that enters W_RESP; a same-edge read sees the old word.
  always_ff @(posedge clock) begin
    if (commit_d) begin
      mem_q[addr_idx(wr_addr_d)] <= merged_d;
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25010008_axil_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25010008_axil_sram
// Description : Bench for the AXI4-Lite SRAM: one instance at default latency,
//               one at zero latency, both tracked by a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25010008_axil_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_25010008_axil_sram_if ifa ();
  ysyx_25010008_axil_sram_if ifb ();

  ysyx_25010008_axil_sram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_LAT(2), .WRITE_LAT(2))
    dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
  ysyx_25010008_axil_sram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_LAT(0), .WRITE_LAT(0))
    dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

  // Bench-side views of both buses, index 0 = dut_a, 1 = dut_b.
  logic [31:0] araddr_v [2], awaddr_v [2], wdata_v [2];
  logic        arvalid_v [2], rready_v [2], awvalid_v [2], wvalid_v [2], bready_v [2];
  logic [3:0]  wstrb_v [2];
  logic [31:0] rdata_o [2];
  logic [1:0]  rresp_o [2], bresp_o [2];
  logic        arready_o [2], rvalid_o [2], awready_o [2], wready_o [2], bvalid_o [2];

  assign ifa.araddr = araddr_v[0]; assign ifa.arvalid = arvalid_v[0]; assign ifa.rready = rready_v[0];
  assign ifa.awaddr = awaddr_v[0]; assign ifa.awvalid = awvalid_v[0]; assign ifa.wdata = wdata_v[0];
  assign ifa.wstrb = wstrb_v[0]; assign ifa.wvalid = wvalid_v[0]; assign ifa.bready = bready_v[0];
  assign ifb.araddr = araddr_v[1]; assign ifb.arvalid = arvalid_v[1]; assign ifb.rready = rready_v[1];
  assign ifb.awaddr = awaddr_v[1]; assign ifb.awvalid = awvalid_v[1]; assign ifb.wdata = wdata_v[1];
  assign ifb.wstrb = wstrb_v[1]; assign ifb.wvalid = wvalid_v[1]; assign ifb.bready = bready_v[1];
  assign arready_o[0] = ifa.arready; assign rvalid_o[0] = ifa.rvalid; assign rdata_o[0] = ifa.rdata;
  assign rresp_o[0] = ifa.rresp; assign awready_o[0] = ifa.awready; assign wready_o[0] = ifa.wready;
  assign bvalid_o[0] = ifa.bvalid; assign bresp_o[0] = ifa.bresp;
  assign arready_o[1] = ifb.arready; assign rvalid_o[1] = ifb.rvalid; assign rdata_o[1] = ifb.rdata;
  assign rresp_o[1] = ifb.rresp; assign awready_o[1] = ifb.awready; assign wready_o[1] = ifb.wready;
  assign bvalid_o[1] = ifb.bvalid; assign bresp_o[1] = ifb.bresp;

  int vec = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    vec++;
    fails++;
    $display("FAIL %s: got no handshake expected one within bound", nm);
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model: per-instance memory image plus outstanding
  // read/write bookkeeping keyed on edge numbers.
  // --------------------------------------------------------------------------
  logic [31:0] mm [2][DEPTH];
  bit          mk [2][DEPTH];
  bit          m_rbusy [2], m_rval [2], m_rknown [2];
  longint      m_rdue [2];
  logic [31:0] m_raddr [2], m_rdata [2];
  logic [1:0]  m_rresp [2];
  bit          m_awh [2], m_wh [2], m_wwait [2], m_bval [2];
  longint      m_wdue [2];
  logic [31:0] m_waddr [2], m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic [1:0]  m_bresp [2];
  longint      edge_n = 0;
  bit          started = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic m_capture(input int d);
    m_rval[d] = 1;
    if (in_rng(m_raddr[d])) begin
      m_rdata[d]  = mm[d][widx(m_raddr[d])];
      m_rknown[d] = mk[d][widx(m_raddr[d])];
      m_rresp[d]  = 2'b00;
    end else begin
      m_rdata[d]  = 32'h0;
      m_rknown[d] = 1;
      m_rresp[d]  = 2'b10;
    end
  endtask

  task automatic m_commit(input int d);
    m_bval[d] = 1;
    if (in_rng(m_waddr[d])) begin
      for (int b = 0; b < 4; b++)
        if (m_wstrb[d][b]) mm[d][widx(m_waddr[d])][8*b +: 8] = m_wdata[d][8*b +: 8];
      if (m_wstrb[d] == 4'hF) mk[d][widx(m_waddr[d])] = 1;
      m_bresp[d] = 2'b00;
    end else begin
      m_bresp[d] = 2'b10;
    end
  endtask

  task automatic m_step(input int d);
    if (reset) begin
      m_rbusy[d] = 0; m_rval[d] = 0; m_rdata[d] = 32'h0; m_rresp[d] = 2'b00; m_rknown[d] = 1;
      m_awh[d] = 0; m_wh[d] = 0; m_wwait[d] = 0; m_bval[d] = 0; m_bresp[d] = 2'b00;
      return;
    end
    // Read side is evaluated first: a same-edge read observes the pre-write word.
    if (!m_rbusy[d]) begin
      if (arvalid_v[d]) begin
        m_rbusy[d] = 1;
        m_raddr[d] = araddr_v[d];
        m_rdue[d]  = edge_n + lat_of(d);
        if (lat_of(d) == 0) m_capture(d);
      end
    end else if (!m_rval[d]) begin
      if (edge_n == m_rdue[d]) m_capture(d);
    end else if (rready_v[d]) begin
      m_rbusy[d] = 0;
      m_rval[d]  = 0;
    end
    if (m_bval[d]) begin
      if (bready_v[d]) begin
        m_bval[d] = 0; m_awh[d] = 0; m_wh[d] = 0;
      end
    end else if (m_wwait[d]) begin
      if (edge_n == m_wdue[d]) begin
        m_wwait[d] = 0;
        m_commit(d);
      end
    end else begin
      if (awvalid_v[d] && !m_awh[d]) begin m_awh[d] = 1; m_waddr[d] = awaddr_v[d]; end
      if (wvalid_v[d] && !m_wh[d]) begin m_wh[d] = 1; m_wdata[d] = wdata_v[d]; m_wstrb[d] = wstrb_v[d]; end
      if (m_awh[d] && m_wh[d]) begin
        if (lat_of(d) == 0) m_commit(d);
        else begin m_wwait[d] = 1; m_wdue[d] = edge_n + lat_of(d); end
      end
    end
  endtask

  always @(posedge clock) begin
    if (reset) started = 1;
    m_step(0);
    m_step(1);
    edge_n++;
  end

  // Every cycle, every output of both instances against the model.
  always @(negedge clock) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("arready[%0d]", d), {31'b0, arready_o[d]}, {31'b0, !m_rbusy[d]});
        chk($sformatf("rvalid[%0d]", d), {31'b0, rvalid_o[d]}, {31'b0, m_rval[d]});
        chk($sformatf("rresp[%0d]", d), {30'b0, rresp_o[d]}, {30'b0, m_rresp[d]});
        if (m_rknown[d]) chk($sformatf("rdata[%0d]", d), rdata_o[d], m_rdata[d]);
        chk($sformatf("awready[%0d]", d), {31'b0, awready_o[d]},
            {31'b0, !(m_wwait[d] || m_bval[d] || m_awh[d])});
        chk($sformatf("wready[%0d]", d), {31'b0, wready_o[d]},
            {31'b0, !(m_wwait[d] || m_bval[d] || m_wh[d])});
        chk($sformatf("bvalid[%0d]", d), {31'b0, bvalid_o[d]}, {31'b0, m_bval[d]});
        chk($sformatf("bresp[%0d]", d), {30'b0, bresp_o[d]}, {30'b0, m_bresp[d]});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus drivers. lead > 0: W goes lead cycles before AW; lead < 0: AW first.
  // --------------------------------------------------------------------------
  task automatic write_tx(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, output logic [1:0] resp);
    int gap;
    bit seen;
    gap  = (lead < 0) ? -lead : lead;
    seen = 0;
    resp = 2'bxx;
    @(posedge clock); #1;
    if (lead >= 0) begin wvalid_v[d] = 1; wdata_v[d] = data; wstrb_v[d] = strb; end
    if (lead <= 0) begin awvalid_v[d] = 1; awaddr_v[d] = addr; end
    if (lead != 0) begin
      @(posedge clock); #1;
      if (lead > 0) wvalid_v[d] = 0; else awvalid_v[d] = 0;
      repeat (gap - 1) @(posedge clock);
      #1;
      if (lead > 0) begin awvalid_v[d] = 1; awaddr_v[d] = addr; end
      else begin wvalid_v[d] = 1; wdata_v[d] = data; wstrb_v[d] = strb; end
    end
    @(posedge clock); #1;
    awvalid_v[d] = 0;
    wvalid_v[d]  = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clock);
      if (bvalid_o[d]) begin seen = 1; resp = bresp_o[d]; end
    end
    if (!seen) tmo("write_bvalid");
  endtask

  task automatic read_tx(input int d, input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    data = 32'hx;
    resp = 2'bxx;
    @(posedge clock); #1;
    arvalid_v[d] = 1;
    araddr_v[d]  = addr;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clock);
      if (arready_o[d]) seen = 1;
    end
    if (!seen) tmo("read_arready");
    @(posedge clock); #1;
    arvalid_v[d] = 0;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clock);
      lat++;
      if (rvalid_o[d]) begin seen = 1; data = rdata_o[d]; resp = rresp_o[d]; end
    end
    if (!seen) begin
      tmo("read_rvalid");
    end else begin
      repeat (hold) @(negedge clock);
      rready_v[d] = 1;
      @(posedge clock); #1;
      rready_v[d] = 0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin : stim
    logic [31:0] rd;
    logic [1:0]  rr, br;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      araddr_v[d] = 0; arvalid_v[d] = 0; rready_v[d] = 0; awaddr_v[d] = 0; awvalid_v[d] = 0;
      wdata_v[d] = 0; wstrb_v[d] = 0; wvalid_v[d] = 0; bready_v[d] = 1;
    end
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // Post-reset state
    @(negedge clock);
    chk("rst_arready", {31'b0, arready_o[0]}, 32'd1);
    chk("rst_awready", {31'b0, awready_o[0]}, 32'd1);
    chk("rst_wready", {31'b0, wready_o[0]}, 32'd1);
    chk("rst_rvalid", {31'b0, rvalid_o[0]}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid_o[0]}, 32'd0);
    chk("rst_rdata", rdata_o[0], 32'd0);
    chk("rst_resp", {28'b0, rresp_o[0], bresp_o[0]}, 32'd0);

    // Full write then read with default latency
    write_tx(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, br);
    chk("wr10_bresp", {30'b0, br}, 32'd0);
    read_tx(0, 32'h8000_0010, 0, rd, rr, lat);
    chk("rd10_data", rd, 32'hDEAD_BEEF);
    chk("rd10_rresp", {30'b0, rr}, 32'd0);
    chk("rd10_latency", lat, 32'd3);

    // W three cycles ahead of AW, one byte lane
    write_tx(0, 32'h8000_0010, 32'h0000_5500, 4'b0010, 3, br);
    chk("wlead_bresp", {30'b0, br}, 32'd0);
    repeat (4) begin
      @(negedge clock);
      chk("wlead_single_b", {31'b0, bvalid_o[0]}, 32'd0);
    end
    chk("model_word4", mm[0][4], 32'hDEAD_55EF);
    read_tx(0, 32'h8000_0010, 0, rd, rr, lat);
    chk("rdlane_data", rd, 32'hDEAD_55EF);

    // AW ahead of W, last word of the window; addr[1:0] ignored on readback
    write_tx(0, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, -2, br);
    chk("wlast_bresp", {30'b0, br}, 32'd0);
    read_tx(0, 32'h8000_0FFF, 0, rd, rr, lat);
    chk("rdlast_data", rd, 32'h0BAD_F00D);
    read_tx(0, 32'h8000_0013, 0, rd, rr, lat);
    chk("rdlow_data", rd, 32'hDEAD_55EF);

    // Zero strobe leaves the word alone but still answers OKAY
    write_tx(0, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, br);
    chk("wzero_bresp", {30'b0, br}, 32'd0);

    // Out-of-range on both sides
    write_tx(0, 32'h8000_0000, 32'h1122_3344, 4'hF, 0, br);
    read_tx(0, 32'h7FFF_FFFC, 0, rd, rr, lat);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_rresp", {30'b0, rr}, 32'd2);
    write_tx(0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, br);
    chk("oor_bresp", {30'b0, br}, 32'd2);
    read_tx(0, 32'h8000_0000, 0, rd, rr, lat);
    chk("oor_word0", rd, 32'h1122_3344);

    // Back-pressured read response
    read_tx(0, 32'h8000_0010, 5, rd, rr, lat);
    chk("hold_data", rd, 32'hDEAD_55EF);

    // Reset while the write is waiting out its latency
    write_tx(0, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 0, br);
    @(posedge clock); #1;
    awvalid_v[0] = 1; awaddr_v[0] = 32'h8000_0020;
    wvalid_v[0] = 1; wdata_v[0] = 32'h1234_5678; wstrb_v[0] = 4'hF;
    @(posedge clock); #1;
    awvalid_v[0] = 0; wvalid_v[0] = 0;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    repeat (6) begin
      @(negedge clock);
      chk("rstw_bvalid", {31'b0, bvalid_o[0]}, 32'd0);
      chk("rstw_readys", {29'b0, arready_o[0], awready_o[0], wready_o[0]}, 32'd7);
    end
    read_tx(0, 32'h8000_0020, 0, rd, rr, lat);
    chk("rstw_word", rd, 32'hCAFE_F00D);

    // Zero-latency instance: same-edge read and write to one word
    write_tx(1, 32'h8000_0040, 32'hAAAA_0001, 4'hF, 0, br);
    @(posedge clock); #1;
    arvalid_v[1] = 1; araddr_v[1] = 32'h8000_0040;
    awvalid_v[1] = 1; awaddr_v[1] = 32'h8000_0040;
    wvalid_v[1] = 1; wdata_v[1] = 32'hBBBB_0002; wstrb_v[1] = 4'hF;
    @(posedge clock); #1;
    arvalid_v[1] = 0; awvalid_v[1] = 0; wvalid_v[1] = 0;
    @(negedge clock);
    chk("same_rvalid", {31'b0, rvalid_o[1]}, 32'd1);
    chk("same_bvalid", {31'b0, bvalid_o[1]}, 32'd1);
    chk("same_old", rdata_o[1], 32'hAAAA_0001);
    rready_v[1] = 1;
    @(posedge clock); #1;
    rready_v[1] = 0;
    read_tx(1, 32'h8000_0040, 0, rd, rr, lat);
    chk("same_new", rd, 32'hBBBB_0002);
    chk("lat0_latency", lat, 32'd1);

    repeat (4) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
